scan_controller: RTL and testbench
==================================

Name: scan_controller

Overview:
- Parametrised multiplexed 7-segment scan controller; next generation of the 8-digit fixed-rate pixel controller.
- Generalises digit count and adds a built-in refresh divider, per-digit blanking, PWM brightness and a frame-start strobe.
- Sits between the board clock and the digit mux / segment decoder: `sel` drives the digit data mux, `anodes` drives the active-low anode pins.

Parameters:
- NUM_DIGITS, 8, number of multiplexed digits (2..16).
- SEL_W, $clog2(NUM_DIGITS), width of `sel`.
- TICK_DIV, 65536, clock cycles per digit slot; must be a multiple of 2**PWM_BITS and at least 2**PWM_BITS.
- PWM_BITS, 4, brightness resolution in bits.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- digit_en  input  NUM_DIGITS  per-digit enable; 0 = blank that digit.
- brightness  input  PWM_BITS  duty level; 0 = dark, all-ones = full on.
- anodes  output  NUM_DIGITS  active-low anode drive, registered.
- sel  output  SEL_W  index of the digit currently scanned, registered.
- frame_start  output  1  one-cycle pulse at the start of slot 0, registered.

Behaviour:
- Single clock. Reset is synchronous, active-low: sampled on posedge clk while reset==0.
- Reset values:
  - div_cnt=0, idx=0.
  - anodes = all ones (every digit off).
  - sel=0, frame_start=0.
  - Latched enable and brightness registers = 0.
- Slot divider:
  - div_cnt counts 0..TICK_DIV-1 and wraps.
  - At div_cnt==TICK_DIV-1, idx advances.
  - idx wraps from NUM_DIGITS-1 to 0. This covers non-power-of-2 NUM_DIGITS: idx never reaches values >= NUM_DIGITS.
- Slot-start latch:
  - On the cycle div_cnt wraps to 0, capture en_q = digit_en[next idx] and br_q = brightness.
  - Mid-slot changes on either input have no effect until the next slot.
- PWM:
  - STEP = TICK_DIV >> PWM_BITS.
  - A digit is lit while en_q==1 and (br_q == all-ones OR div_cnt < br_q*STEP).
  - br_q==0 means never lit; all-ones means lit for the entire slot.
- Outputs are registered and derived from the state in the same cycle, giving one cycle of latency from state to pins.
  - anodes = ~(one-hot(idx)) when lit, else all ones.
  - At most one anodes bit is low at any time.
  - sel = idx at all times, including blanked slots, so data muxing is unaffected.
- frame_start = 1 for exactly the first cycle of slot 0 (idx==0, div_cnt==0), once per NUM_DIGITS*TICK_DIV cycles.
- Reset mid-slot: the next cycle shows the reset values, and scanning restarts at slot 0. The first frame_start after reset is asserted in the first cycle after reset deasserts.
- Anode handover: there is no cycle in which two anodes are low. At a slot boundary the old digit's bit rises in the same cycle the new digit's bit falls.
- All-zero digit_en: anodes stays all ones, while sel and frame_start continue normally.

Decomposition:
- Shared package `display_pkg`:
  - ANODE_OFF constant (active-low polarity).
  - Default TICK_DIV for the 100 MHz board clock.
  - onehot_n function (index -> active-low one-hot).
- One natural sub-module: `tick_divider` (parametrised modulo counter with terminal-count output), reused by other display and debounce blocks.

Test Plan:
All scenarios run with NUM_DIGITS=4 (SEL_W=2), TICK_DIV=16, PWM_BITS=2 (STEP=4).
1. Reset held 3 cycles, then digit_en=4'hF, brightness=2'b11 -> anodes sequence 1110,1101,1011,0111, each held 16 cycles; sel=0,1,2,3; frame_start high once every 64 cycles, first in the cycle after reset release.
2. brightness=2'b01, digit_en=4'hF -> each slot shows the anode low for 4 cycles then high for 12; brightness=0 -> anodes all ones for a full frame, sel still cycling.
3. digit_en=4'b1010 -> anodes low only in slots 1 and 3; slots 0 and 2 all ones; sel unaffected.
4. Toggle brightness from 3 to 0 at div_cnt=5 of slot 2 -> slot 2 stays fully lit; slot 3 is dark.
5. Assert reset at div_cnt=9 of slot 3 -> next cycle anodes=4'hF, sel=0; after release scanning restarts at slot 0 with a frame_start pulse.
6. Run 1000 frames with random digit_en/brightness -> assertion that at most one anodes bit is low every cycle and frame_start period is exactly 64.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants and helpers for the multiplexed display blocks.
package display_pkg;

    localparam int MAX_DIGITS = 16;

    // Anode pins are active-low: all ones means every digit is dark.
    localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

    // 65536 cycles per slot at 100 MHz gives ~190 Hz frame rate with 8 digits.
    localparam int DEFAULT_TICK_DIV = 65536;

    function automatic logic [MAX_DIGITS-1:0] onehot_n(input logic [3:0] idx);
        logic [MAX_DIGITS-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        return ~oh;
    endfunction

endpackage

// File: rtl/scan_controller_if.sv
// Digit-enable/brightness inputs and anode/select/frame outputs of the scan controller.
interface scan_controller_if #(
    parameter int NUM_DIGITS = 8,
    parameter int PWM_BITS   = 4
);
    localparam int SEL_W = $clog2(NUM_DIGITS);

    logic [NUM_DIGITS-1:0] digit_en;
    logic [PWM_BITS-1:0]   brightness;
    logic [NUM_DIGITS-1:0] anodes;
    logic [SEL_W-1:0]      sel;
    logic                  frame_start;

    modport master (
        output digit_en, brightness,
        input  anodes, sel, frame_start
    );

    modport slave (
        input  digit_en, brightness,
        output anodes, sel, frame_start
    );

endinterface

// File: rtl/tick_divider.sv
// Free-running modulo-DIV counter with a terminal-count flag on the last value.
// Latency: tc is combinational from count. Backpressure: none, always counts.
module tick_divider #(
    parameter int unsigned DIV = 16,
    parameter int          W   = $clog2(DIV)
) (
    input  logic         clk,
    input  logic         reset,
    output logic [W-1:0] count,
    output logic         tc
);

    assign tc = (count == W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (tc) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/scan_controller.sv
// Multiplexed 7-segment scanner: per-slot digit select, blanking, PWM brightness, frame strobe.
// Latency: pins are registered, one cycle after the slot state. Backpressure: none, free-running.
module scan_controller
    import display_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SEL_W      = $clog2(NUM_DIGITS),
    parameter int TICK_DIV   = DEFAULT_TICK_DIV,
    parameter int PWM_BITS   = 4
) (
    input  logic              clk,
    input  logic              reset,
    scan_controller_if.slave  bus
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam int STEP  = TICK_DIV >> PWM_BITS;

    logic [CNT_W-1:0]    div_cnt;
    logic                slot_end;
    logic                slot_first;
    logic [SEL_W-1:0]    idx;
    logic                en_q;
    logic [PWM_BITS-1:0] br_q;
    logic                en_cur;
    logic [PWM_BITS-1:0] br_cur;
    logic [CNT_W-1:0]    pwm_thr;
    logic                lit;

    tick_divider #(
        .DIV (TICK_DIV),
        .W   (CNT_W)
    ) u_div (
        .clk   (clk),
        .reset (reset),
        .count (div_cnt),
        .tc    (slot_end)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            idx <= '0;
        end else if (slot_end) begin
            idx <= (idx == SEL_W'(NUM_DIGITS - 1)) ? '0 : idx + SEL_W'(1);
        end
    end

    assign slot_first = (div_cnt == '0);

    // The first cycle of a slot uses the live inputs (also covers the slot right after
    // reset); they are held for the rest of the slot so mid-slot changes are ignored.
    assign en_cur = slot_first ? bus.digit_en[idx] : en_q;
    assign br_cur = slot_first ? bus.brightness    : br_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            en_q <= 1'b0;
            br_q <= '0;
        end else if (slot_first) begin
            en_q <= bus.digit_en[idx];
            br_q <= bus.brightness;
        end
    end

    assign pwm_thr = CNT_W'(br_cur) * CNT_W'(STEP);
    assign lit     = en_cur && ((br_cur == '1) || (div_cnt < pwm_thr));

    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.anodes      <= NUM_DIGITS'(ANODE_OFF);
            bus.sel         <= '0;
            bus.frame_start <= 1'b0;
        end else begin
            bus.anodes      <= lit ? NUM_DIGITS'(onehot_n(4'(idx))) : NUM_DIGITS'(ANODE_OFF);
            bus.sel         <= idx;
            bus.frame_start <= slot_first && (idx == '0);
        end
    end

endmodule

// File: tb/tb_scan_controller.sv
// Bench for scan_controller with 4 digits, 16-cycle slots and 2-bit brightness.
module tb_scan_controller;

    localparam int ND    = 4;
    localparam int TD    = 16;
    localparam int PB    = 2;
    localparam int STEP  = TD >> PB;
    localparam int FRAME = ND * TD;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    scan_controller_if #(.NUM_DIGITS(ND), .PWM_BITS(PB)) bus ();

    scan_controller #(
        .NUM_DIGITS (ND),
        .SEL_W      (2),
        .TICK_DIV   (TD),
        .PWM_BITS   (PB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int k           = 0;
    int last_fs     = 0;
    bit have_fs     = 0;
    logic       en_l = 1'b0;
    logic [1:0] br_l = 2'b00;
    int low_cnt [ND];
    int fs_cnt      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // One clock: model samples inputs at the edge, DUT outputs compared on the falling edge.
    task automatic cycle();
        logic [3:0] ea;
        logic [1:0] es;
        logic       ef;
        int d, s;
        bit lit;
        @(posedge clk);
        cyc++;
        if (!reset) begin
            ea = 4'hF; es = 2'd0; ef = 1'b0;
            k = 0;
            have_fs = 0;
        end else begin
            d = k % TD;
            s = (k / TD) % ND;
            if (d == 0) begin
                en_l = bus.digit_en[s];
                br_l = bus.brightness;
            end
            lit = en_l && (br_l == 2'b11 || d < int'(br_l) * STEP);
            ea = 4'hF;
            if (lit) ea[s] = 1'b0;
            es = 2'(s);
            ef = (k % FRAME == 0);
            k++;
        end
        @(negedge clk);
        check("anodes", 32'(bus.anodes), 32'(ea));
        check("sel", 32'(bus.sel), 32'(es));
        check("frame_start", 32'(bus.frame_start), 32'(ef));
        check("one_low_max", 32'($countones(~bus.anodes) <= 1), 32'd1);
        if (bus.frame_start) begin
            if (have_fs) check("fs_period", 32'(cyc - last_fs), 32'(FRAME));
            last_fs = cyc;
            have_fs = 1;
            fs_cnt++;
        end
        for (int i = 0; i < ND; i++) if (!bus.anodes[i]) low_cnt[i]++;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < ND; i++) low_cnt[i] = 0;
        fs_cnt = 0;
    endtask

    task automatic do_reset(input logic [3:0] en, input logic [1:0] br);
        reset = 1'b0;
        bus.digit_en = en;
        bus.brightness = br;
        repeat (3) cycle();
        reset = 1'b1;
    endtask

    typedef struct {
        logic [3:0]      en;
        logic [1:0]      br;
        logic [3:0][4:0] low;   // expected low cycles per digit over one frame
    } frame_vec_t;

    frame_vec_t tbl [6];

    initial begin
        bus.digit_en   = '0;
        bus.brightness = '0;

        tbl[0] = '{en: 4'hF,    br: 2'b11, low: {5'd16, 5'd16, 5'd16, 5'd16}};
        tbl[1] = '{en: 4'hF,    br: 2'b01, low: {5'd4,  5'd4,  5'd4,  5'd4 }};
        tbl[2] = '{en: 4'hF,    br: 2'b00, low: {5'd0,  5'd0,  5'd0,  5'd0 }};
        tbl[3] = '{en: 4'b1010, br: 2'b11, low: {5'd16, 5'd0,  5'd16, 5'd0 }};
        tbl[4] = '{en: 4'b0101, br: 2'b10, low: {5'd0,  5'd8,  5'd0,  5'd8 }};
        tbl[5] = '{en: 4'b0011, br: 2'b01, low: {5'd0,  5'd0,  5'd4,  5'd4 }};

        for (int t = 0; t < 6; t++) begin
            do_reset(tbl[t].en, tbl[t].br);
            clear_counts();
            repeat (FRAME) cycle();
            for (int i = 0; i < ND; i++)
                check($sformatf("tbl%0d_low%0d", t, i), 32'(low_cnt[i]), 32'(tbl[t].low[i]));
            check($sformatf("tbl%0d_fs_count", t), 32'(fs_cnt), 32'd1);
        end

        // Brightness drops mid-slot 2: slot 2 keeps its latched level, slot 3 goes dark.
        do_reset(4'hF, 2'b11);
        repeat (2 * TD + 6) cycle();
        bus.brightness = 2'b00;
        clear_counts();
        repeat (2 * TD - 6) cycle();
        check("midslot_slot2_held", 32'(low_cnt[2]), 32'(TD - 6));
        check("midslot_slot3_dark", 32'(low_cnt[3]), 32'd0);

        // Reset in the middle of slot 3, then restart at slot 0 with a frame strobe.
        do_reset(4'hF, 2'b11);
        repeat (3 * TD + 9) cycle();
        reset = 1'b0;
        cycle();
        check("rst_mid_anodes", 32'(bus.anodes), 32'hF);
        check("rst_mid_sel", 32'(bus.sel), 32'd0);
        reset = 1'b1;
        cycle();
        check("restart_fs", 32'(bus.frame_start), 32'd1);
        check("restart_sel", 32'(bus.sel), 32'd0);
        check("restart_anodes", 32'(bus.anodes), 32'hE);
        repeat (FRAME) cycle();

        // Random enable/brightness traffic for 1000 frames.
        do_reset(4'(($urandom)), 2'($urandom));
        clear_counts();
        for (int n = 0; n < 1000 * FRAME; n++) begin
            if ($urandom_range(7) == 0) bus.digit_en = 4'($urandom);
            if ($urandom_range(7) == 0) bus.brightness = 2'($urandom);
            cycle();
        end
        check("random_fs_count", 32'(fs_cnt), 32'd1000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
